// File: rtl/latch_event_sync_pkg.sv
// Shared types and constants for the latch event synchronizer.
// Optional event counters are enabled with the LATCH_EVENT_SYNC_CNT_EN macro.
package latch_event_sync_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      CLEAR = 2'd2
   } chan_state_t;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_SAT) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/latch_event_sync_chan.sv
// One event channel: synchronizer, IDLE/PULSE/CLEAR handshake with the upstream latch,
// stuck-latch detection and, with LATCH_EVENT_SYNC_CNT_EN, a saturating event counter.
module latch_event_sync_chan
   import latch_event_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STUCK_LIMIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lq,
   input  logic             cnt_clr,
   output logic             lclr,
   output logic             evt,
   output logic             busy,
   output logic             stuck,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STUCK_LIMIT - 1);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_q;
   chan_state_t            state;
   chan_state_t            next_state;
   logic [CNT_W-1:0]       clr_cnt;
   logic [CNT_W-1:0]       clr_cnt_n;
   logic                   stuck_n;
   logic                   evt_n;

   assign sync_q = sync_ff[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], lq};
      end
   end

   // Once the stuck fault fires the channel parks in CLEAR until reset.
   always_comb begin
      next_state = state;
      clr_cnt_n  = clr_cnt;
      stuck_n    = stuck;
      evt_n      = 1'b0;
      case (state)
         IDLE: begin
            if (sync_q) begin
               next_state = PULSE;
               evt_n      = 1'b1;
               clr_cnt_n  = '0;
            end
         end
         PULSE: begin
            next_state = CLEAR;
         end
         CLEAR: begin
            if (!stuck) begin
               if (!sync_q) begin
                  next_state = IDLE;
               end else begin
                  clr_cnt_n = clr_cnt + 8'd1;
                  if (clr_cnt == LIMIT_M1) begin
                     stuck_n = 1'b1;
                  end
               end
            end
         end
         default: begin
            next_state = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         stuck   <= 1'b0;
         evt     <= 1'b0;
         lclr    <= 1'b1;
         busy    <= 1'b1;
      end else begin
         state   <= next_state;
         clr_cnt <= clr_cnt_n;
         stuck   <= stuck_n;
         evt     <= evt_n;
         lclr    <= (next_state != IDLE);
         busy    <= (next_state != IDLE);
      end
   end

`ifdef LATCH_EVENT_SYNC_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // A clear request wins over an increment landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (evt) begin
         cnt_q <= sat_inc(cnt_q);
      end
   end

   assign evt_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign evt_cnt        = '0;
`endif

endmodule

// File: rtl/latch_event_sync.sv
// Top level: WIDTH independent channels turning asynchronous latch flags into one-cycle events.
// Define LATCH_EVENT_SYNC_CNT_EN to add per-channel 8-bit event counters on EVT_CNT.
module latch_event_sync
   import latch_event_sync_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STUCK_LIMIT = 15
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   LQ,
   output logic [WIDTH-1:0]   LCLR,
   output logic [WIDTH-1:0]   EVT,
   output logic [WIDTH-1:0]   BUSY,
   output logic [WIDTH-1:0]   STUCK,
   input  logic               CNT_CLR,
   output logic [8*WIDTH-1:0] EVT_CNT
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      latch_event_sync_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .STUCK_LIMIT(STUCK_LIMIT)
      ) u_chan (
         .clk     (CLK),
         .rst     (RST),
         .lq      (LQ[i]),
         .cnt_clr (CNT_CLR),
         .lclr    (LCLR[i]),
         .evt     (EVT[i]),
         .busy    (BUSY[i]),
         .stuck   (STUCK[i]),
         .evt_cnt (EVT_CNT[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_latch_event_sync.sv
// Self-checking bench for latch_event_sync: vector table, directed corner cases and random traffic
// against a behavioural model. Counter checks follow LATCH_EVENT_SYNC_CNT_EN.
module tb_latch_event_sync;

   localparam int WIDTH = 4;
   localparam int SS    = 2;
   localparam int LIM   = 15;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CNT_CLR;
   logic [3:0]  LQ;
   logic [3:0]  LCLR;
   logic [3:0]  EVT;
   logic [3:0]  BUSY;
   logic [3:0]  STUCK;
   logic [31:0] EVT_CNT;

   int total = 0;
   int bad   = 0;

   logic [3:0] hist[$];
   bit         m_evt[WIDTH];
   bit         m_lclr[WIDTH];
   bit         m_stuck[WIDTH];
   int         m_clrcnt[WIDTH];
   int         m_ecnt[WIDTH];

   typedef struct {
      bit         rst;
      logic [3:0] lq;
      logic [3:0] evt;
      logic [3:0] lclr;
      logic [3:0] busy;
   } vec_t;

   vec_t tbl[12];

   always #5 CLK = ~CLK;

   latch_event_sync #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SS),
      .STUCK_LIMIT(LIM)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .LQ      (LQ),
      .LCLR    (LCLR),
      .EVT     (EVT),
      .BUSY    (BUSY),
      .STUCK   (STUCK),
      .CNT_CLR (CNT_CLR),
      .EVT_CNT (EVT_CNT)
   );

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flag seen by the channel FSM is the LQ value sampled SS edges earlier.
   task automatic modelEdge();
      logic [3:0] sq;
      bit         old_evt;
      if (RST) begin
         hist.delete();
         for (int k = 0; k < SS; k++) hist.push_back(4'b0000);
         for (int i = 0; i < WIDTH; i++) begin
            m_evt[i] = 0; m_lclr[i] = 1; m_stuck[i] = 0; m_clrcnt[i] = 0; m_ecnt[i] = 0;
         end
      end else begin
         sq = hist.pop_front();
         hist.push_back(LQ);
         for (int i = 0; i < WIDTH; i++) begin
            old_evt = m_evt[i];
`ifdef LATCH_EVENT_SYNC_CNT_EN
            if (CNT_CLR) m_ecnt[i] = 0;
            else if (old_evt && m_ecnt[i] < 255) m_ecnt[i]++;
`endif
            if (!m_lclr[i]) begin
               if (sq[i]) begin
                  m_evt[i] = 1; m_lclr[i] = 1; m_clrcnt[i] = 0;
               end
            end else if (old_evt) begin
               m_evt[i] = 0;
            end else if (!m_stuck[i]) begin
               if (!sq[i]) begin
                  m_lclr[i] = 0;
               end else begin
                  m_clrcnt[i]++;
                  if (m_clrcnt[i] == LIM) m_stuck[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [3:0]  e_evt, e_lclr, e_stuck;
      logic [31:0] e_cnt;
      for (int i = 0; i < WIDTH; i++) begin
         e_evt[i]          = m_evt[i];
         e_lclr[i]         = m_lclr[i];
         e_stuck[i]        = m_stuck[i];
         e_cnt[i*8 +: 8]   = 8'(m_ecnt[i]);
      end
      expectEq("model_evt", {28'd0, EVT}, {28'd0, e_evt});
      expectEq("model_lclr", {28'd0, LCLR}, {28'd0, e_lclr});
      expectEq("model_busy", {28'd0, BUSY}, {28'd0, e_lclr});
      expectEq("model_stuck", {28'd0, STUCK}, {28'd0, e_stuck});
      expectEq("model_evt_cnt", EVT_CNT, e_cnt);
   endtask

   task automatic applyStimulus(input bit rst, input logic [3:0] lq, input bit clr);
      RST     = rst;
      LQ      = lq;
      CNT_CLR = clr;
      @(posedge CLK);
      modelEdge();
      @(negedge CLK);
      checkOutput();
   endtask

   initial begin
      int         evt_seen;
      logic [3:0] rlq;
      RST = 1'b1; LQ = '0; CNT_CLR = 1'b0;

      tbl[0]  = '{1, 4'h0, 4'h0, 4'hF, 4'hF};
      tbl[1]  = '{0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[3]  = '{0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{0, 4'h0, 4'h1, 4'h1, 4'h1};
      tbl[5]  = '{0, 4'h0, 4'h0, 4'h1, 4'h1};
      tbl[6]  = '{0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[7]  = '{0, 4'hF, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{0, 4'h0, 4'hF, 4'hF, 4'hF};
      tbl[10] = '{0, 4'h0, 4'h0, 4'hF, 4'hF};
      tbl[11] = '{0, 4'h0, 4'h0, 4'h0, 4'h0};

      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].rst, tbl[i].lq, 1'b0);
         expectEq($sformatf("tbl%0d_evt", i), {28'd0, EVT}, {28'd0, tbl[i].evt});
         expectEq($sformatf("tbl%0d_lclr", i), {28'd0, LCLR}, {28'd0, tbl[i].lclr});
         expectEq($sformatf("tbl%0d_busy", i), {28'd0, BUSY}, {28'd0, tbl[i].busy});
      end

      // Channel 1 held high: one event, then stuck after LIM clear cycles.
      applyStimulus(1'b1, 4'h0, 1'b0);
      evt_seen = 0;
      for (int k = 1; k <= 19; k++) begin
         applyStimulus(1'b0, 4'b0010, 1'b0);
         if (EVT[1]) evt_seen++;
         if (k == 3) expectEq("stuck_evt_edge3", {31'd0, EVT[1]}, 32'd1);
         if (k == 18) expectEq("stuck_not_yet", {31'd0, STUCK[1]}, 32'd0);
      end
      expectEq("stuck_set", {31'd0, STUCK[1]}, 32'd1);
      expectEq("stuck_lclr_held", {31'd0, LCLR[1]}, 32'd1);
      expectEq("stuck_single_evt", evt_seen, 32'd1);

      // Reset in the middle of CLEAR discards everything.
      applyStimulus(1'b1, 4'b0010, 1'b0);
      expectEq("rst_lclr", {28'd0, LCLR}, 32'hF);
      expectEq("rst_evt", {28'd0, EVT}, 32'h0);
      expectEq("rst_stuck", {28'd0, STUCK}, 32'h0);
      applyStimulus(1'b0, 4'h0, 1'b0);
      expectEq("rst_release_busy", {28'd0, BUSY}, 32'h0);

      // 300 events on channel 2 saturate its counter.
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'b0, 4'b0100, 1'b0);
         repeat (5) applyStimulus(1'b0, 4'h0, 1'b0);
      end
`ifdef LATCH_EVENT_SYNC_CNT_EN
      expectEq("cnt_saturated", {24'd0, EVT_CNT[23:16]}, 32'd255);
`else
      expectEq("cnt_disabled", EVT_CNT, 32'd0);
`endif
      applyStimulus(1'b0, 4'b0100, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0);
      expectEq("cnt_clr_evt_high", {31'd0, EVT[2]}, 32'd1);
      applyStimulus(1'b0, 4'h0, 1'b1);
      expectEq("cnt_clr_wins", {24'd0, EVT_CNT[23:16]}, 32'd0);
      repeat (3) applyStimulus(1'b0, 4'h0, 1'b0);

      // Random traffic, occasional resets and counter clears.
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < WIDTH; b++) rlq[b] = ($urandom_range(3) == 0);
         applyStimulus($urandom_range(63) == 0, rlq, $urandom_range(15) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
